valrdy_serializer: RTL and testbench

- Val/rdy transmitter: accepts one bitwidth-wide message from upstream, then sends it downstream as nbeats narrow beats, one per accepted downstream handshake.
- Sits at the sending end of a narrow val/rdy link, for example ahead of a narrow bus or SPI/serial front end.
- Its partner is a capture stage that registers incoming beats on val & rdy.

---
 rtl/valrdy_pkg.sv | 14 +
 rtl/ff.sv | 21 ++
 rtl/valrdy_serializer.sv | 145 ++++++++++++++
 tb/tb_valrdy_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/valrdy_pkg.sv
// Shared types and helpers for the val/rdy serializer.
package valrdy_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Beat counter width; a single-beat message still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ff.sv
// Generic enable flop with asynchronous active-high reset.
module ff #(
    parameter int unsigned          Width    = 1,
    parameter logic [Width-1:0]     ResetVal = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= ResetVal;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/valrdy_serializer.sv
// Val/rdy serializer: one wide message in, nbeats narrow beats out.
// Define VALRDY_SER_MSB_FIRST_EN to emit the most-significant beat first.
module valrdy_serializer
    import valrdy_pkg::*;
#(
    parameter int unsigned bitwidth = 32,
    parameter int unsigned nbeats   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         snd_val,
    output logic                         snd_rdy,
    input  logic [bitwidth-1:0]          snd_msg,
    output logic                         rcv_val,
    input  logic                         rcv_rdy,
    output logic [bitwidth/nbeats-1:0]   rcv_msg,
    output logic                         rcv_last
);

    localparam int unsigned     BW      = bitwidth / nbeats;
    localparam int unsigned     CW      = cnt_width(nbeats);
    localparam logic [CW-1:0]   LastCnt = CW'(nbeats - 1);

    if ((nbeats < 1) || ((bitwidth % nbeats) != 0)) begin : g_param_err
        $error("valrdy_serializer: bitwidth must be a non-zero multiple of nbeats");
    end

    state_e              r_state;
    logic                r_state_raw;
    state_e              w_state_d;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_d;
    logic                w_cnt_en;
    logic [bitwidth-1:0] r_sreg;
    logic [bitwidth-1:0] w_sreg_d;
    logic [bitwidth-1:0] w_sreg_shift;
    logic [BW-1:0]       w_beat;
    logic                w_last;
    logic                w_up_xfer;
    logic                w_dn_xfer;

    ff #(
        .Width    (1),
        .ResetVal (1'b0)
    ) u_state_ff (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (1'b1),
        .i_d   (w_state_d),
        .o_q   (r_state_raw)
    );

    assign r_state = state_e'(r_state_raw);

    ff #(
        .Width    (CW),
        .ResetVal ('0)
    ) u_cnt_ff (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_cnt_en),
        .i_d   (w_cnt_d),
        .o_q   (r_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg <= '0;
        end else begin
            r_sreg <= w_sreg_d;
        end
    end

`ifdef VALRDY_SER_MSB_FIRST_EN
    assign w_beat       = r_sreg[bitwidth-1 -: BW];
    assign w_sreg_shift = r_sreg << BW;
`else
    assign w_beat       = r_sreg[BW-1:0];
    assign w_sreg_shift = r_sreg >> BW;
`endif

    assign w_last    = (r_state == SEND) && (r_cnt == LastCnt);
    assign w_up_xfer = snd_val & snd_rdy;
    assign w_dn_xfer = rcv_val & rcv_rdy;

    // Next-state: state, beat counter and shift register.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cnt_en  = 1'b0;
        w_sreg_d  = r_sreg;
        unique case (r_state)
            IDLE: begin
                if (w_up_xfer) begin
                    w_sreg_d  = snd_msg;
                    w_cnt_d   = '0;
                    w_cnt_en  = 1'b1;
                    w_state_d = SEND;
                end
            end
            SEND: begin
                if (w_dn_xfer) begin
                    if (!w_last) begin
                        w_sreg_d = w_sreg_shift;
                        w_cnt_d  = r_cnt + CW'(1);
                        w_cnt_en = 1'b1;
                    end else if (snd_val) begin
                        // Reload on the final beat so back-to-back messages have no bubble.
                        w_sreg_d = snd_msg;
                        w_cnt_d  = '0;
                        w_cnt_en = 1'b1;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Outputs; snd_rdy is combinational on rcv_rdy during the final beat.
    always_comb begin
        snd_rdy  = 1'b0;
        rcv_val  = 1'b0;
        rcv_msg  = '0;
        rcv_last = 1'b0;
        unique case (r_state)
            IDLE: begin
                snd_rdy = 1'b1;
            end
            SEND: begin
                rcv_val  = 1'b1;
                rcv_msg  = w_beat;
                rcv_last = w_last;
                snd_rdy  = w_last & rcv_rdy;
            end
            default: begin
                snd_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_valrdy_serializer.sv
// Self-checking bench for valrdy_serializer (32/4 instance plus an 8/1 instance).
module tb_valrdy_serializer;

    logic        clk;
    logic        reset;
    logic        snd_val;
    logic        snd_rdy;
    logic [31:0] snd_msg;
    logic        rcv_val;
    logic        rcv_rdy;
    logic [7:0]  rcv_msg;
    logic        rcv_last;

    logic        snd_val1;
    logic        snd_rdy1;
    logic [7:0]  snd_msg1;
    logic        rcv_val1;
    logic        rcv_rdy1;
    logic [7:0]  rcv_msg1;
    logic        rcv_last1;

    int checks = 0;
    int errors = 0;

    valrdy_serializer #(
        .bitwidth (32),
        .nbeats   (4)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .snd_val  (snd_val),
        .snd_rdy  (snd_rdy),
        .snd_msg  (snd_msg),
        .rcv_val  (rcv_val),
        .rcv_rdy  (rcv_rdy),
        .rcv_msg  (rcv_msg),
        .rcv_last (rcv_last)
    );

    valrdy_serializer #(
        .bitwidth (8),
        .nbeats   (1)
    ) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .snd_val  (snd_val1),
        .snd_rdy  (snd_rdy1),
        .snd_msg  (snd_msg1),
        .rcv_val  (rcv_val1),
        .rcv_rdy  (rcv_rdy1),
        .rcv_msg  (rcv_msg1),
        .rcv_last (rcv_last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sv;
        logic [7:0] msg;
        logic       rr;
        logic       e_rdy;
        logic       e_val;
        logic [7:0] e_msg;
        logic       e_last;
    } vec_t;

    vec_t tbl [11];

    // Beat idx of message m in emission order.
    function automatic logic [7:0] exp_beat(input logic [31:0] m, input int idx);
`ifdef VALRDY_SER_MSB_FIRST_EN
        return m[8*(3-idx) +: 8];
`else
        return m[8*idx +: 8];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one message, then expect its four beats back to back with rcv_rdy=1.
    task automatic send_one(input string tag, input logic [31:0] m);
        snd_val = 1'b1;
        snd_msg = m;
        rcv_rdy = 1'b1;
        #1;
        check({tag, " snd_rdy idle"}, 32'(snd_rdy), 32'd1);
        tick();
        snd_val = 1'b0;
        snd_msg = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check({tag, " rcv_val"}, 32'(rcv_val), 32'd1);
            check({tag, " rcv_msg"}, 32'(rcv_msg), 32'(exp_beat(m, i)));
            check({tag, " rcv_last"}, 32'(rcv_last), 32'(i == 3));
            check({tag, " snd_rdy"}, 32'(snd_rdy), 32'(i == 3));
            tick();
        end
        #1;
        check({tag, " idle after"}, 32'(rcv_val), 32'd0);
    endtask

    logic [7:0] q [$];
    logic       m_rdy;

    initial begin
        reset    = 1'b0;
        snd_val  = 1'b0;
        snd_msg  = '0;
        rcv_rdy  = 1'b0;
        snd_val1 = 1'b0;
        snd_msg1 = '0;
        rcv_rdy1 = 1'b0;

        // Test 1: async reset with no clock edge.
        #3;
        reset = 1'b1;
        #1;
        check("t1 reset rcv_val", 32'(rcv_val), 32'd0);
        check("t1 reset snd_rdy", 32'(snd_rdy), 32'd1);
        check("t1 reset rcv_msg", 32'(rcv_msg), 32'd0);
        check("t1 reset rcv_last", 32'(rcv_last), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1 idle rcv_val", 32'(rcv_val), 32'd0);
        end

        // Test 2: single message, no stall.
        send_one("t2", 32'hDDCCBBAA);

        // Test 3: back-to-back messages with no bubble.
        snd_val = 1'b1;
        snd_msg = 32'h44332211;
        rcv_rdy = 1'b1;
        tick();
        snd_msg = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t3 rcv_val", 32'(rcv_val), 32'd1);
            check("t3 rcv_msg", 32'(rcv_msg),
                  32'(exp_beat((i < 4) ? 32'h44332211 : 32'h88776655, i % 4)));
            check("t3 snd_rdy", 32'(snd_rdy), 32'((i % 4) == 3));
            tick();
            if (i == 3) snd_val = 1'b0;
        end
        #1;
        check("t3 idle after", 32'(rcv_val), 32'd0);

        // Test 4: downstream stall on the second beat.
        tick();
        snd_val = 1'b1;
        snd_msg = 32'hDDCCBBAA;
        tick();
        snd_val = 1'b0;
        #1;
        check("t4 beat0", 32'(rcv_msg), 32'(exp_beat(32'hDDCCBBAA, 0)));
        tick();
        rcv_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4 stall val", 32'(rcv_val), 32'd1);
            check("t4 stall msg", 32'(rcv_msg), 32'(exp_beat(32'hDDCCBBAA, 1)));
            check("t4 stall last", 32'(rcv_last), 32'd0);
            check("t4 stall snd_rdy", 32'(snd_rdy), 32'd0);
            tick();
        end
        rcv_rdy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            check("t4 resume msg", 32'(rcv_msg), 32'(exp_beat(32'hDDCCBBAA, i)));
            check("t4 resume last", 32'(rcv_last), 32'(i == 3));
            tick();
        end
        #1;
        check("t4 idle after", 32'(rcv_val), 32'd0);

        // Test 5: reset mid-message, then a clean message.
        tick();
        snd_val = 1'b1;
        snd_msg = 32'hDDCCBBAA;
        tick();
        snd_val = 1'b0;
        tick();
        tick();
        #1;
        check("t5 pre-reset msg", 32'(rcv_msg), 32'(exp_beat(32'hDDCCBBAA, 2)));
        reset = 1'b1;
        #1;
        check("t5 reset rcv_val", 32'(rcv_val), 32'd0);
        check("t5 reset snd_rdy", 32'(snd_rdy), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        send_one("t5", 32'h01020304);

        // Randomized traffic against a beat-queue model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            tick();
            snd_val = ($urandom_range(0, 99) < 40);
            snd_msg = $urandom;
            rcv_rdy = ($urandom_range(0, 99) < 70);
            #1;
            m_rdy = (q.size() == 0) || ((q.size() == 1) && rcv_rdy);
            check("rnd rcv_val", 32'(rcv_val), 32'(q.size() != 0));
            check("rnd snd_rdy", 32'(snd_rdy), 32'(m_rdy));
            if (q.size() != 0) begin
                check("rnd rcv_msg", 32'(rcv_msg), 32'(q[0]));
                check("rnd rcv_last", 32'(rcv_last), 32'(q.size() == 1));
            end
            if ((q.size() != 0) && rcv_rdy) void'(q.pop_front());
            if (snd_val && m_rdy) begin
                for (int b = 0; b < 4; b++) q.push_back(exp_beat(snd_msg, b));
            end
        end
        tick();
        snd_val = 1'b0;
        rcv_rdy = 1'b1;

        // Single-beat instance: per-cycle vectors.
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1};
        tbl[4]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 11; i++) begin
            tick();
            snd_val1 = tbl[i].sv;
            snd_msg1 = tbl[i].msg;
            rcv_rdy1 = tbl[i].rr;
            #1;
            check("nb1 snd_rdy", 32'(snd_rdy1), 32'(tbl[i].e_rdy));
            check("nb1 rcv_val", 32'(rcv_val1), 32'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                check("nb1 rcv_msg", 32'(rcv_msg1), 32'(tbl[i].e_msg));
                check("nb1 rcv_last", 32'(rcv_last1), 32'(tbl[i].e_last));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
